ema_mc: RTL
===========

EMA_MC -- requirements
Module: ema_mc

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning sample and output width (signed Q(DATA_W).0).
REQ-002 The block SHALL have parameter ALPHA_W, default 15, meaning coefficient width (unsigned Q0.ALPHA_W).
REQ-003 The block SHALL have parameter CH, default 4, meaning the number of independent filter channels; CH_W = max(1, clog2(CH)).
REQ-004 The block SHALL have parameter ALPHA_RST, default 9830, meaning the per-channel alpha after reset (0.3).
REQ-005 The block SHALL have the following ports, clock and reset first:
- clk  in  1  clock, one clock only; all logic on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- x_i  in  DATA_W  signed input sample.
- ch_i  in  CH_W  channel of x_i.
- valid_i  in  1  sample request.
- alpha_i  in  ALPHA_W  coefficient write data.
- alpha_ch_i  in  CH_W  coefficient write channel.
- alpha_we_i  in  1  coefficient write enable.
- clear_i  in  1  synchronous clear of all channel state.
- y_o  out  DATA_W  signed filtered output.
- ch_o  out  CH_W  channel of y_o.
- valid_o  out  1  one-cycle output strobe.
- busy_o  out  1  high while a sample is in flight.

Function
REQ-006 Each channel c SHALL compute y[c] <= y[c] + round((x - y[c]) * alpha[c] / 2^ALPHA_W).
REQ-007 FSM states SHALL be IDLE, SUB, MUL, OUT; IDLE->SUB on valid_i & !busy_o; SUB->MUL; MUL->OUT; OUT->IDLE, each unconditional on the next edge.
REQ-008 On acceptance, x_i, ch_i and alpha[ch_i] SHALL be latched; the stored y and alpha of that channel SHALL be used unchanged for the whole operation.
REQ-009 busy_o SHALL be high whenever state != IDLE; valid_i while busy_o is high SHALL be ignored, with no queueing.
REQ-010 y_o, ch_o and valid_o SHALL be registered on the OUT->IDLE edge; valid_o SHALL be high exactly the 4th cycle after the acceptance edge.
REQ-011 The same edge SHALL write the new y into channel state; a new sample SHALL be acceptable on the edge that ends the valid_o cycle (throughput 1 per 4 cycles).
REQ-012 y_o and ch_o SHALL hold their value until the next valid_o.
REQ-013 The difference SHALL be DATA_W+1 bits signed; the product SHALL be DATA_W+ALPHA_W+2 bits signed; alpha SHALL be zero-extended.
REQ-014 Rounding SHALL be: add 2^(ALPHA_W-1), then arithmetic right shift by ALPHA_W (round half up).
REQ-015 The sum SHALL saturate to the signed DATA_W range.
REQ-016 alpha_we_i SHALL write alpha[alpha_ch_i] on any cycle; the write SHALL affect only operations accepted after it.
REQ-017 clear_i SHALL zero all y, set all init flags, return the FSM to IDLE, and suppress the in-flight valid_o; clear_i has priority over valid_i on the same edge.
REQ-018 alpha = 0 SHALL hold y; channels SHALL be fully independent.
REQ-019 An out-of-range ch_i (>= CH) SHALL be ignored, like a busy request.

Reset
REQ-020 rst_n low SHALL asynchronously set: y_o = 0, ch_o = 0, valid_o = 0, busy_o = 0, FSM = IDLE, all y = 0, all alpha = ALPHA_RST, all init flags = 1; deassertion is synchronous to clk.

Configuration
REQ-021 With macro EMA_INIT_EN defined, the first accepted sample per channel after reset or clear SHALL bypass the arithmetic: y = x, same latency, and the init flag is cleared.
REQ-022 Without EMA_INIT_EN, no init flags SHALL exist and every sample SHALL follow REQ-006 from y = 0.

Structure
REQ-023 Package ema_pkg SHALL hold the FSM state enum, default parameter values and the rounding-constant function.
REQ-024 Sub-module ema_round_sat SHALL be combinational (product, y_prev -> rounded, saturated y_new) and shared by all channels.

Verification (DATA_W=16, ALPHA_W=15, CH=4)
REQ-025 The bench SHALL cover: EMA_INIT_EN off, alpha[0]=16384, ch0 x=1000 twice -> y_o=500 then 750, ch_o=0, valid_o exactly 4 cycles after each acceptance.
REQ-026 The bench SHALL cover rounding: alpha=9830, y=0, x=1 -> 0; x=32767 -> 9830; alpha=16384, y=0, x=-3 -> -1.
REQ-027 The bench SHALL cover: EMA_INIT_EN on, ch1 x=-2000 -> y_o=-2000; then x=0 with alpha 16384 -> -1000.
REQ-028 The bench SHALL cover isolation: ch2 x=100 (alpha 16384) -> 50; then ch3 x=0 -> 0; alpha_we to ch3 does not change ch2 results.
REQ-029 The bench SHALL cover: valid_i pulsed 1 cycle after an acceptance -> exactly one valid_o, busy_o high for 3 cycles.
REQ-030 The bench SHALL cover: clear_i in MUL -> no valid_o, busy_o low next cycle; next ch0 x=1000 -> 500 (init off).

Source files
------------

// File: rtl/ema_pkg.sv
// ema_pkg: shared definitions for the multi-channel exponential moving average
// filter (ema_mc): FSM state encoding, default parameter values and the
// rounding-constant helper used by the round/saturate stage.
package ema_pkg;

    // Operation sequencer: accept -> subtract -> multiply -> write back/output.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        MUL  = 2'd2,
        OUT  = 2'd3
    } ema_state_t;

    localparam int DATA_W_DEF    = 16;
    localparam int ALPHA_W_DEF   = 15;
    localparam int CH_DEF        = 4;
    localparam int ALPHA_RST_DEF = 9830;   // 0.3 in Q0.15

    // Channel index width; a single channel still gets a 1-bit select.
    function automatic int ch_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

    // Half an LSB of the alpha scaling: added before the shift so the
    // arithmetic right shift rounds half up.
    function automatic longint round_const(input int alpha_w);
        return longint'(1) << (alpha_w - 1);
    endfunction

endpackage

// File: rtl/ema_round_sat.sv
// ema_round_sat: combinational back end shared by all channels.
// Scales the (x - y) * alpha product back to sample units with round-half-up,
// adds it to the previous output and clamps to the signed DATA_W range.
module ema_round_sat
    import ema_pkg::*;
#(
    parameter  int DATA_W  = DATA_W_DEF,
    parameter  int ALPHA_W = ALPHA_W_DEF,
    localparam int PROD_W  = DATA_W + ALPHA_W + 2
) (
    input  logic signed [PROD_W-1:0] prod,
    input  logic signed [DATA_W-1:0] y_prev,
    output logic signed [DATA_W-1:0] y_new
);

    localparam logic signed [PROD_W-1:0] RC    = PROD_W'(round_const(ALPHA_W));
    localparam logic signed [PROD_W-1:0] Y_MAX = PROD_W'((longint'(1) << (DATA_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] Y_MIN = -Y_MAX - PROD_W'(1);

    logic signed [PROD_W-1:0] delta;
    logic signed [PROD_W-1:0] sum;

    // Round the scaled step, accumulate onto y and saturate.
    always_comb begin
        delta = (prod + RC) >>> ALPHA_W;
        sum   = delta + PROD_W'(y_prev);
        if (sum > Y_MAX) begin
            y_new = Y_MAX[DATA_W-1:0];
        end else if (sum < Y_MIN) begin
            y_new = Y_MIN[DATA_W-1:0];
        end else begin
            y_new = sum[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/ema_mc.sv
// ema_mc: time-multiplexed exponential moving average over CH channels.
// One sample is processed at a time through IDLE -> SUB -> MUL -> OUT; the
// result is written back to the channel state and presented on y_o on the
// OUT -> IDLE edge (valid_o the 4th cycle after acceptance).
// Optional feature: define EMA_INIT_EN so that the first sample of each
// channel after reset or clear loads y = x directly instead of filtering.
module ema_mc
    import ema_pkg::*;
#(
    parameter  int DATA_W    = DATA_W_DEF,
    parameter  int ALPHA_W   = ALPHA_W_DEF,
    parameter  int CH        = CH_DEF,
    parameter  int ALPHA_RST = ALPHA_RST_DEF,
    localparam int CH_W      = ch_width(CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] x_i,
    input  logic [CH_W-1:0]          ch_i,
    input  logic                     valid_i,
    input  logic [ALPHA_W-1:0]       alpha_i,
    input  logic [CH_W-1:0]          alpha_ch_i,
    input  logic                     alpha_we_i,
    input  logic                     clear_i,
    output logic signed [DATA_W-1:0] y_o,
    output logic [CH_W-1:0]          ch_o,
    output logic                     valid_o,
    output logic                     busy_o
);

    localparam int DIFF_W = DATA_W + 1;
    localparam int PROD_W = DATA_W + ALPHA_W + 2;

    ema_state_t state_reg, state_next;
    logic       accept;
    logic       y_write;

    // Operand latches for the operation in flight
    logic signed [DATA_W-1:0] x_reg;
    logic signed [DATA_W-1:0] y_prev_reg;
    logic [CH_W-1:0]          ch_reg;
    logic [ALPHA_W-1:0]       alpha_reg;
    logic signed [DIFF_W-1:0] diff_reg;
    logic signed [PROD_W-1:0] prod_reg;
    logic signed [DATA_W-1:0] y_new;
    logic signed [DATA_W-1:0] y_wr;

    // Per-channel state viewed as arrays for indexed reads
    logic signed [DATA_W-1:0] y_mem     [CH];
    logic [ALPHA_W-1:0]       alpha_mem [CH];
`ifdef EMA_INIT_EN
    logic                     init_mem  [CH];
    logic                     init_reg;
`endif

    // A clear on the OUT edge discards the result, so nothing is written back.
    assign y_write = (state_reg == OUT) && !clear_i;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; clear overrides everything and aborts the operation
    always_comb begin
        state_next = state_reg;
        if (clear_i) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (accept) state_next = SUB;
                SUB:     state_next = MUL;
                MUL:     state_next = OUT;
                OUT:     state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM outputs: busy flag and request acceptance (busy or bad channel -> drop)
    always_comb begin
        busy_o = (state_reg != IDLE);
        accept = valid_i && !busy_o && !clear_i && (int'(ch_i) < CH);
    end

    // Datapath pipeline: latch operands, form the difference, then the product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg      <= '0;
            y_prev_reg <= '0;
            ch_reg     <= '0;
            alpha_reg  <= '0;
            diff_reg   <= '0;
            prod_reg   <= '0;
        end else begin
            if (accept) begin
                x_reg      <= x_i;
                y_prev_reg <= y_mem[ch_i];
                ch_reg     <= ch_i;
                alpha_reg  <= alpha_mem[ch_i];
            end
            if (state_reg == SUB) begin
                diff_reg <= DIFF_W'(x_reg) - DIFF_W'(y_prev_reg);
            end
            if (state_reg == MUL) begin
                // alpha is an unsigned fraction: zero-extend before the signed multiply
                prod_reg <= PROD_W'(diff_reg) * PROD_W'($signed({1'b0, alpha_reg}));
            end
        end
    end

`ifdef EMA_INIT_EN
    // Remember whether this operation is the channel's first since reset/clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_reg <= 1'b0;
        end else if (accept) begin
            init_reg <= init_mem[ch_i];
        end
    end

    assign y_wr = init_reg ? x_reg : y_new;
`else
    assign y_wr = y_new;
`endif

    ema_round_sat #(
        .DATA_W  (DATA_W),
        .ALPHA_W (ALPHA_W)
    ) u_round_sat (
        .prod   (prod_reg),
        .y_prev (y_prev_reg),
        .y_new  (y_new)
    );

    // Output registers; y_o/ch_o hold between results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_o     <= '0;
            ch_o    <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= y_write;
            if (y_write) begin
                y_o  <= y_wr;
                ch_o <= ch_reg;
            end
        end
    end

    // Per-channel filter state and coefficient registers
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        logic signed [DATA_W-1:0] y_ch_reg;
        logic [ALPHA_W-1:0]       alpha_ch_reg;
        logic                     hit;

        assign hit = y_write && (ch_reg == CH_W'(gi));

        // Filter output state: cleared by reset/clear, updated on write-back
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                y_ch_reg <= '0;
            end else if (clear_i) begin
                y_ch_reg <= '0;
            end else if (hit) begin
                y_ch_reg <= y_wr;
            end
        end

        // Coefficient: writable any cycle, an in-flight op keeps its latched copy
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                alpha_ch_reg <= ALPHA_W'(ALPHA_RST);
            end else if (alpha_we_i && (alpha_ch_i == CH_W'(gi))) begin
                alpha_ch_reg <= alpha_i;
            end
        end

        assign y_mem[gi]     = y_ch_reg;
        assign alpha_mem[gi] = alpha_ch_reg;

`ifdef EMA_INIT_EN
        logic init_ch_reg;

        // First-sample flag: set by reset/clear, dropped once the channel is written
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                init_ch_reg <= 1'b1;
            end else if (clear_i) begin
                init_ch_reg <= 1'b1;
            end else if (hit) begin
                init_ch_reg <= 1'b0;
            end
        end

        assign init_mem[gi] = init_ch_reg;
`endif
    end

endmodule
